// File: rtl/wb_trace_fifo.sv
// Write-back trace FIFO: records every architectural register write with a
// cycle stamp and PC, and hands entries to a host over a valid/ready handshake.
module wb_trace_fifo #(
  parameter int DEPTH     = 8,
  parameter bit IGNORE_R0 = 1'b1,
  parameter int CNT_W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_en,
  input  logic [4:0]               wb_addr,
  input  logic [31:0]              wb_data,
  input  logic [31:0]              wb_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         out_cycle,
  output logic [4:0]               out_addr,
  output logic [31:0]              out_data,
  output logic [31:0]              out_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [CNT_W-1:0] cyc_mem_q  [DEPTH];
  logic [4:0]       addr_mem_q [DEPTH];
  logic [31:0]      data_mem_q [DEPTH];
  logic [31:0]      pc_mem_q   [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  logic push_req, full, empty, pop, wr_en, drop;

  always_comb begin
    push_req   = wb_en && !(IGNORE_R0 && (wb_addr == 5'd0));
    full       = (count_q == FULL_CNT);
    empty      = (count_q == '0);
    pop        = !empty && out_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    wr_en      = push_req && (!full || pop);
    drop       = push_req && full && !pop;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    cyc_d      = cyc_q + 1'b1;
    overflow_d = overflow_q | drop;
    drop_cnt_d = drop_cnt_q;

    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cyc_q      <= CNT_W'(1);
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cyc_q      <= cyc_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage needs no reset: reads are masked to zero while empty.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      cyc_mem_q[wr_ptr_q]  <= cyc_q;
      addr_mem_q[wr_ptr_q] <= wb_addr;
      data_mem_q[wr_ptr_q] <= wb_data;
      pc_mem_q[wr_ptr_q]   <= wb_pc;
    end
  end

  always_comb begin
    out_valid = !empty;
    out_cycle = empty ? '0 : cyc_mem_q[rd_ptr_q];
    out_addr  = empty ? '0 : addr_mem_q[rd_ptr_q];
    out_data  = empty ? '0 : data_mem_q[rd_ptr_q];
    out_pc    = empty ? '0 : pc_mem_q[rd_ptr_q];
    count     = count_q;
    overflow  = overflow_q;
    drop_cnt  = drop_cnt_q;
  end

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Directed bench for wb_trace_fifo: expected entries are queued when a write is
// driven and compared in order as the FIFO drains.
module tb_wb_trace_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_cycle;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic [31:0] out_pc;
  logic [3:0]  count;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;
  logic [31:0]  next_stamp = 32'd1;
  logic [100:0] sb [$];

  wb_trace_fifo #(.DEPTH(8), .IGNORE_R0(1'b1), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_pc(wb_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_cycle(out_cycle), .out_addr(out_addr), .out_data(out_data),
    .out_pc(out_pc), .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and track the stamp the DUT will give the next write.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) next_stamp = 32'd1;
    else     next_stamp = next_stamp + 32'd1;
  endtask

  task automatic drive(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
    wb_en   = 1'b1;
    wb_addr = a;
    wb_data = d;
    wb_pc   = p;
  endtask

  task automatic idle();
    wb_en   = 1'b0;
    wb_addr = 'x;
    wb_data = 'x;
    wb_pc   = 'x;
  endtask

  function automatic logic [100:0] ent(input logic [31:0] c, input logic [4:0] a,
                                       input logic [31:0] d, input logic [31:0] p);
    return {c, a, d, p};
  endfunction

  task automatic drain_all(input string tag);
    int budget = 64;
    idle();
    out_ready = 1'b1;
    while (sb.size() > 0 && budget > 0) begin
      if (out_valid) begin
        chk(tag, {27'b0, out_cycle, out_addr, out_data, out_pc}, {27'b0, sb[0]});
        sb.delete(0);
      end
      tick();
      budget--;
    end
    chk({tag, "_left"}, 128'(sb.size()), 128'd0);
    sb.delete();
    out_ready = 1'b0;
    chk({tag, "_valid_end"}, 128'(out_valid), 128'd0);
    chk({tag, "_count_end"}, 128'(count), 128'd0);
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    idle();
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", 128'(out_valid), 128'd0);
    chk("rst_count", 128'(count), 128'd0);
    chk("rst_ovf", 128'(overflow), 128'd0);
    chk("rst_drop", 128'(drop_cnt), 128'd0);
    chk("rst_fields", {27'b0, out_cycle, out_addr, out_data, out_pc}, 128'd0);

    // First write lands on the 6th edge after reset.
    repeat (5) tick();
    drive(5'd23, 32'd20, 32'd216);
    sb.push_back(ent(next_stamp, 5'd23, 32'd20, 32'd216));
    tick();
    idle();
    chk("t1_valid", 128'(out_valid), 128'd1);
    chk("t1_head", {27'b0, out_cycle, out_addr, out_data, out_pc},
        {27'b0, ent(32'd6, 5'd23, 32'd20, 32'd216)});
    chk("t1_count", 128'(count), 128'd1);

    repeat (5) tick();
    chk("t1_hold", {27'b0, out_cycle, out_addr, out_data, out_pc},
        {27'b0, ent(32'd6, 5'd23, 32'd20, 32'd216)});
    drive(5'd24, 32'd35, 32'd220);
    sb.push_back(ent(next_stamp, 5'd24, 32'd35, 32'd220));
    tick();
    chk("t2_count", 128'(count), 128'd2);
    chk("t2_stamp", {27'b0, sb[1]}, {27'b0, ent(32'd12, 5'd24, 32'd35, 32'd220)});
    drain_all("t2_drain");

    drive(5'd0, 32'd99, 32'd300);
    tick();
    idle();
    chk("r0_count", 128'(count), 128'd0);
    chk("r0_valid", 128'(out_valid), 128'd0);

    // Fill, then push and pop on the same edge while full.
    for (int i = 1; i <= 8; i++) begin
      drive(5'd7, 32'(i + 40), 32'h2000 + 32'(4 * i));
      sb.push_back(ent(next_stamp, 5'd7, 32'(i + 40), 32'h2000 + 32'(4 * i)));
      tick();
    end
    idle();
    chk("full_count", 128'(count), 128'd8);
    chk("full_ovf", 128'(overflow), 128'd0);
    out_ready = 1'b1;
    drive(5'd9, 32'd100, 32'h3000);
    chk("pp_head", {27'b0, out_cycle, out_addr, out_data, out_pc}, {27'b0, sb[0]});
    sb.delete(0);
    sb.push_back(ent(next_stamp, 5'd9, 32'd100, 32'h3000));
    tick();
    out_ready = 1'b0;
    idle();
    chk("pp_count", 128'(count), 128'd8);
    chk("pp_ovf", 128'(overflow), 128'd0);
    chk("pp_drop", 128'(drop_cnt), 128'd0);
    drain_all("pp_drain");

    // Nine pushes into eight slots: one is lost.
    for (int i = 1; i <= 9; i++) begin
      drive(5'd3, 32'(i), 32'h1000 + 32'(4 * i));
      if (sb.size() < 8) sb.push_back(ent(next_stamp, 5'd3, 32'(i), 32'h1000 + 32'(4 * i)));
      tick();
    end
    idle();
    chk("ovf_count", 128'(count), 128'd8);
    chk("ovf_flag", 128'(overflow), 128'd1);
    chk("ovf_drop", 128'(drop_cnt), 128'd1);
    drain_all("ovf_drain");
    chk("ovf_sticky", 128'(overflow), 128'd1);

    // Drop counter saturates at 255.
    for (int i = 0; i < 8 + 260; i++) begin
      drive(5'd4, 32'(i), 32'd0);
      tick();
    end
    idle();
    chk("sat_drop", 128'(drop_cnt), 128'd255);
    chk("sat_count", 128'(count), 128'd8);

    // Reset mid-operation with a write pending on the reset edge.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(5'd5, 32'(i), 32'd0);
      tick();
    end
    chk("pre_rst_count", 128'(count), 128'd3);
    rst = 1'b1;
    drive(5'd6, 32'd77, 32'd0);
    tick();
    rst = 1'b0;
    idle();
    chk("mid_rst_valid", 128'(out_valid), 128'd0);
    chk("mid_rst_count", 128'(count), 128'd0);
    chk("mid_rst_ovf", 128'(overflow), 128'd0);
    chk("mid_rst_drop", 128'(drop_cnt), 128'd0);
    drive(5'd8, 32'd55, 32'h4000);
    sb.push_back(ent(next_stamp, 5'd8, 32'd55, 32'h4000));
    tick();
    idle();
    chk("post_rst_stamp", 128'(out_cycle), 128'd1);
    drain_all("post_rst_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
